// File: rtl/me_pkg.sv
// Shared types for the motion-estimation result sequencer.
package me_pkg;

  // Default field widths carried in a queued result. The sequencer's DIST_W/MV_W
  // parameters and $clog2(NUM_BLOCKS)+1 are expected to match these.
  localparam int unsigned DefDistW = 8;
  localparam int unsigned DefMvW   = 4;
  localparam int unsigned DefIdxW  = 3;

  typedef struct packed {
    logic [DefDistW-1:0] distance;
    logic [DefMvW-1:0]   mv_x;
    logic [DefMvW-1:0]   mv_y;
    logic [DefIdxW-1:0]  block_idx;
    logic                timeout;
  } me_result_t;

  typedef enum logic [2:0] {
    StIdle,
    StWaitSlot,
    StLaunch,
    StCapture,
    StGap
  } seq_state_e;

endpackage

// File: rtl/me_result_fifo.sv
// Small synchronous FIFO of me_result_t; head is read straight from storage registers.
module me_result_fifo
  import me_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  me_result_t               data_i,
  input  logic                     pop_i,
  output me_result_t               data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  me_result_t            mem_q [DEPTH];
  logic [PtrW-1:0]       wptr_q, rptr_q;
  logic [PtrW:0]         count_q;
  logic                  do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // A push into a full FIFO is only legal when the head leaves on the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage, pointers (wrap naturally, DEPTH is a power of two) and occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= data_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/me_result_sequencer.sv
// Launches the ME core once per macroblock, queues tagged results and accumulates frame SAD.
module me_result_sequencer
  import me_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DIST_W     = DefDistW,
  parameter int unsigned MV_W       = DefMvW,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  run,
  output logic                                  busy,
  output logic                                  me_start,
  input  logic                                  me_completed,
  input  logic [DIST_W-1:0]                     me_best_distance,
  input  logic [MV_W-1:0]                       me_motion_x,
  input  logic [MV_W-1:0]                       me_motion_y,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DIST_W-1:0]                     out_distance,
  output logic [MV_W-1:0]                       out_mv_x,
  output logic [MV_W-1:0]                       out_mv_y,
  output logic [$clog2(NUM_BLOCKS):0]           out_block_idx,
  output logic                                  out_timeout,
  output logic [DIST_W+$clog2(NUM_BLOCKS):0]    frame_sad,
  output logic                                  frame_done
);

  localparam int unsigned IdxW = $clog2(NUM_BLOCKS) + 1;
  localparam int unsigned SadW = DIST_W + IdxW;
  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  seq_state_e        state_q, state_d;
  logic [IdxW-1:0]   blk_q, blk_d;
  logic [SadW-1:0]   sad_q, sad_d;
  logic [WdW-1:0]    wdog_q;
  logic              comp_prev_q;
  me_result_t        cap_q, cap_d;

  me_result_t        head;
  logic              fifo_full, fifo_empty, fifo_push, push;
  logic [CntW-1:0]   fifo_count;
  logic              pop, slot_free, comp_rise, wdog_hit;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // Occupancy is judged after the pop happening this cycle.
  assign slot_free = (fifo_count < CntW'(DEPTH)) || pop;
  assign comp_rise = me_completed && !comp_prev_q;
  assign wdog_hit  = (wdog_q == WdW'(TIMEOUT - 1));
  assign fifo_push = push && (!fifo_full || pop);

  me_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (fifo_push),
    .data_i  (cap_q),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // State, block counter, SAD accumulator, captured result and completion edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      blk_q       <= '0;
      sad_q       <= '0;
      cap_q       <= '0;
      comp_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      sad_q       <= sad_d;
      cap_q       <= cap_d;
      comp_prev_q <= me_completed;
    end
  end

  // Watchdog counts cycles spent waiting on the core in LAUNCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_q <= '0;
    end else if (state_q == StLaunch) begin
      wdog_q <= wdog_q + 1'b1;
    end else begin
      wdog_q <= '0;
    end
  end

  // Next-state logic and the core/handshake strobes.
  always_comb begin
    state_d    = state_q;
    blk_d      = blk_q;
    sad_d      = sad_q;
    cap_d      = cap_q;
    push       = 1'b0;
    me_start   = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          blk_d   = '0;
          sad_d   = '0;
          state_d = StWaitSlot;
        end
      end
      StWaitSlot: begin
        if (slot_free && !me_completed) begin
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        me_start = 1'b1;
        // A completion on the watchdog's last cycle still counts as real data.
        if (comp_rise) begin
          cap_d.distance  = DefDistW'(me_best_distance);
          cap_d.mv_x      = DefMvW'(me_motion_x);
          cap_d.mv_y      = DefMvW'(me_motion_y);
          cap_d.block_idx = DefIdxW'(blk_q);
          cap_d.timeout   = 1'b0;
          state_d         = StCapture;
        end else if (wdog_hit) begin
          cap_d.distance  = '1;
          cap_d.mv_x      = '0;
          cap_d.mv_y      = '0;
          cap_d.block_idx = DefIdxW'(blk_q);
          cap_d.timeout   = 1'b1;
          state_d         = StCapture;
        end
      end
      StCapture: begin
        me_start = 1'b1;
        push     = 1'b1;
        sad_d    = sad_q + SadW'(cap_q.distance);
        blk_d    = blk_q + 1'b1;
        state_d  = StGap;
      end
      StGap: begin
        if (blk_q < IdxW'(NUM_BLOCKS)) begin
          state_d = StWaitSlot;
        end else begin
          frame_done = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy          = (state_q != StIdle);
  assign frame_sad     = sad_q;
  assign out_distance  = DIST_W'(head.distance);
  assign out_mv_x      = MV_W'(head.mv_x);
  assign out_mv_y      = MV_W'(head.mv_y);
  assign out_block_idx = IdxW'(head.block_idx);
  assign out_timeout   = head.timeout;

endmodule

// File: tb/tb_me_result_sequencer.sv
// Randomized bench: a latency-driven core model plus a queue of expected results.
module tb_me_result_sequencer;

  localparam int NB    = 4;
  localparam int DEPTH = 2;
  localparam int TO    = 50;

  logic        clk = 1'b0;
  logic        reset, run, out_ready;
  logic        me_completed = 1'b0;
  logic [7:0]  me_best_distance = '0;
  logic [3:0]  me_motion_x = '0, me_motion_y = '0;
  logic        busy, me_start, out_valid, out_timeout, frame_done;
  logic [7:0]  out_distance;
  logic [3:0]  out_mv_x, out_mv_y;
  logic [2:0]  out_block_idx;
  logic [10:0] frame_sad;

  me_result_sequencer #(
    .NUM_BLOCKS (NB),
    .DEPTH      (DEPTH),
    .DIST_W     (8),
    .MV_W       (4),
    .TIMEOUT    (TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .run              (run),
    .busy             (busy),
    .me_start         (me_start),
    .me_completed     (me_completed),
    .me_best_distance (me_best_distance),
    .me_motion_x      (me_motion_x),
    .me_motion_y      (me_motion_y),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_distance     (out_distance),
    .out_mv_x         (out_mv_x),
    .out_mv_y         (out_mv_y),
    .out_block_idx    (out_block_idx),
    .out_timeout      (out_timeout),
    .frame_sad        (frame_sad),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic [3:0] x;
    logic [3:0] y;
    int         idx;
    bit         to;
  } exp_t;

  exp_t exp_q[$];
  int   force_lat[$], force_dist[$], force_mx[$], force_my[$];
  int   blk_model = 0, sad_model = 0, launches = 0, pops = 0, frame_launches = 0;
  int   frames_done = 0;
  bit   start_prev = 0, hold = 0;
  int   cnt = 0, lat = 0;
  logic [20:0] held;

  // Core model and scoreboard: a block completes `lat` cycles after its start,
  // lat==0 meaning never; anything slower than TO becomes a timeout entry.
  always @(negedge clk) begin
    exp_t e;
    int d, x, y;
    if (reset) begin
      me_completed = 1'b0;
      start_prev   = 0;
      cnt          = 0;
      hold         = 0;
    end else begin
      if (hold && out_valid)
        check_eq("head stable", {out_distance, out_mv_x, out_mv_y, out_block_idx, out_timeout}, held);
      hold = out_valid && !out_ready;
      held = {out_distance, out_mv_x, out_mv_y, out_block_idx, out_timeout};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious entry", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          check_eq("out_distance", out_distance, e.d);
          check_eq("out_mv_x", out_mv_x, e.x);
          check_eq("out_mv_y", out_mv_y, e.y);
          check_eq("out_block_idx", out_block_idx, 64'(e.idx));
          check_eq("out_timeout", out_timeout, e.to);
        end
        pops++;
      end
      if (me_start) begin
        if (!start_prev) begin
          launches++;
          frame_launches++;
          check_eq("launch with free slot", 64'((launches - pops) <= DEPTH), 64'd1);
          lat = (force_lat.size() != 0) ? force_lat.pop_front()
              : (($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 45)));
          d = (force_dist.size() != 0) ? force_dist.pop_front() : int'($urandom_range(0, 255));
          x = (force_mx.size() != 0) ? force_mx.pop_front() : int'($urandom_range(0, 15));
          y = (force_my.size() != 0) ? force_my.pop_front() : int'($urandom_range(0, 15));
          me_best_distance = 8'(d);
          me_motion_x      = 4'(x);
          me_motion_y      = 4'(y);
          if (lat == 0 || lat > TO) e = '{d: 8'hff, x: 4'd0, y: 4'd0, idx: blk_model, to: 1'b1};
          else e = '{d: 8'(d), x: 4'(x), y: 4'(y), idx: blk_model, to: 1'b0};
          exp_q.push_back(e);
          sad_model += int'(e.d);
          blk_model++;
          cnt = 0;
        end
        cnt++;
        if (lat != 0 && cnt == lat) me_completed = 1'b1;
      end else begin
        me_completed = 1'b0;
        cnt          = 0;
      end
      start_prev = me_start;
      if (frame_done) begin
        frames_done++;
        check_eq("frame_sad", frame_sad, 64'(sad_model));
        check_eq("blocks per frame", 64'(blk_model), 64'(NB));
      end
    end
  end

  task automatic start_frame();
    bit was_empty;
    was_empty      = (exp_q.size() == 0);
    blk_model      = 0;
    sad_model      = 0;
    frame_launches = 0;
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    check_eq("busy after run", busy, 1'b1);
    if (was_empty) begin
      @(posedge clk);
      #1 check_eq("me_start at t+2", me_start, 1'b1);
    end
  endtask

  task automatic wait_done(input int budget, input bit rnd_ready);
    int  start;
    bit  seen;
    start = frames_done;
    seen  = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk);
      if (frames_done != start) seen = 1;
      else if (rnd_ready) #1 out_ready = 1'($urandom_range(0, 1));
    end
    #1 check_eq("busy after frame_done", busy, 1'b0);
    repeat (3) @(posedge clk);
    check_eq("frame_done pulses", 64'(frames_done - start), 64'd1);
  endtask

  task automatic drain(input int budget);
    #1 out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
    check_eq("drained", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check_eq("out_valid after drain", out_valid, 1'b0);
  endtask

  task automatic wait_block(input int n, input int budget);
    for (int i = 0; i < budget && blk_model < n; i++) @(posedge clk);
    check_eq("reached block", 64'(blk_model >= n), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    out_ready = 1'b0;
    #2;
    check_eq("reset me_start", me_start, 1'b0);
    check_eq("reset busy", busy, 1'b0);
    check_eq("reset out_valid", out_valid, 1'b0);
    check_eq("reset frame_done", frame_done, 1'b0);
    check_eq("reset frame_sad", frame_sad, 11'd0);
    check_eq("reset out fields", {out_distance, out_mv_x, out_mv_y, out_block_idx, out_timeout}, 21'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic frame: fixed latency 20, distances 10..40.
    out_ready = 1'b1;
    force_lat  = '{20, 20, 20, 20};
    force_dist = '{10, 20, 30, 40};
    start_frame();
    wait_done(2000, 0);
    check_eq("basic frame_sad", frame_sad, 11'd100);
    drain(100);

    // Backpressure: only DEPTH launches until the consumer accepts.
    out_ready = 1'b0;
    force_lat = '{20, 20, 20, 20};
    start_frame();
    repeat (300) @(posedge clk);
    #1;
    check_eq("launches under backpressure", 64'(frame_launches), 64'(DEPTH));
    check_eq("me_start held low", me_start, 1'b0);
    check_eq("busy under backpressure", busy, 1'b1);
    out_ready = 1'b1;
    wait_done(2000, 0);
    drain(100);

    // Timeout: block1 never completes, block2 at the boundary, block3 one late.
    force_lat = '{5, 0, TO, TO + 1};
    start_frame();
    wait_done(2000, 0);
    drain(100);

    // Signed passthrough of extreme MVs with a saturated distance.
    force_lat  = '{10};
    force_dist = '{255};
    force_mx   = '{8};
    force_my   = '{7};
    start_frame();
    wait_done(2000, 0);
    drain(100);

    // Random frames with a randomly stalling consumer.
    for (int f = 0; f < 6; f++) begin
      start_frame();
      wait_done(3000, 1);
      drain(100);
    end

    // A run pulse while busy is ignored.
    start_frame();
    wait_block(3, 2000);
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    wait_done(2000, 0);
    drain(100);

    // Mid-frame reset at block 2 clears everything; next frame restarts at index 0.
    start_frame();
    wait_block(3, 2000);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("async reset me_start", me_start, 1'b0);
    check_eq("async reset busy", busy, 1'b0);
    check_eq("async reset out_valid", out_valid, 1'b0);
    check_eq("async reset frame_sad", frame_sad, 11'd0);
    exp_q.delete();
    force_lat.delete();
    force_dist.delete();
    force_mx.delete();
    force_my.delete();
    launches = 0;
    pops = 0;
    @(posedge clk);
    #1 reset = 1'b0;
    start_frame();
    wait_done(2000, 0);
    drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/me_result_sequencer.md
# me_result_sequencer

Sequencing and result-buffering stage directly downstream of the motion-estimation core.
- Launches the core once per macroblock of a frame by driving its start input.
- Captures best distance and motion vector on each completion, tags them with the block index and queues them in a small FIFO.
- Presents queued results to the next stage over a valid/ready handshake, accumulates the frame's total distance, and flags runs that exceed a cycle budget.

## Interface
Parameters:
- NUM_BLOCKS, 4: macroblocks per frame (≥1).
- DEPTH, 4: result FIFO entries (power of two, ≥2).
- DIST_W, 8: best-distance width (core saturates at all-ones).
- MV_W, 4: signed motion-vector component width (range −8..+7).
- TIMEOUT, 4096: maximum cycles from me_start rise to me_completed before a block is abandoned.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- run  in  1  one-cycle pulse; starts a frame. Ignored unless idle.
- busy  out  1  high from the cycle after an accepted run until frame_done.
- me_start  out  1  start to motion-estimation core.
- me_completed  in  1  core done flag, level.
- me_best_distance  in  DIST_W  core result.
- me_motion_x, me_motion_y  in  MV_W  signed core result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_distance  out  DIST_W.
- out_mv_x, out_mv_y  out  MV_W.
- out_block_idx  out  $clog2(NUM_BLOCKS)+1.
- out_timeout  out  1  entry produced by timeout, not by completion.
- frame_sad  out  DIST_W+$clog2(NUM_BLOCKS)+1  running sum of pushed distances. Cleared on accepted run.
- frame_done  out  1  one-cycle pulse after the last block is pushed.

## Operation
- States: IDLE, WAIT_SLOT, LAUNCH, CAPTURE, GAP.
- IDLE: on run, clear block counter and frame_sad, then go to WAIT_SLOT.
- WAIT_SLOT: me_start=0. Leave for LAUNCH only when the FIFO count is below DEPTH (counted after any same-cycle pop) and me_completed=0.
- LAUNCH: me_start=1. A watchdog counts cycles in this state.
  - Rising edge of me_completed (current high, previous-cycle low) goes to CAPTURE with the core data.
  - Watchdog reaching TIMEOUT goes to CAPTURE with distance all-ones, MVs 0 and timeout=1.
- CAPTURE: me_start=1. Push {distance, mv_x, mv_y, block_idx, timeout}, add distance to frame_sad, increment block counter. Next state is GAP.
- GAP: me_start=0 for at least one cycle.
  - If blocks remain, go to WAIT_SLOT.
  - Otherwise pulse frame_done and go to IDLE.
- Push never fails: a launch only happens with a free slot, and only one block is in flight.
- FIFO pop occurs when out_valid && out_ready. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo DEPTH.
- The FIFO keeps draining in every state, including IDLE after frame_done.
- A run pulse while busy is dropped silently.
- frame_sad uses unsigned arithmetic and is sized so it cannot overflow for NUM_BLOCKS saturated distances.
- MVs are passed through bit-exact. No sign extension or clipping.

## Timing
- Reset values:
  - me_start=0, busy=0, out_valid=0, frame_done=0, frame_sad=0.
  - out_distance, out_mv_x, out_mv_y, out_block_idx and out_timeout all 0.
  - FSM in IDLE, FIFO empty.
- Reset mid-frame abandons the block in flight. me_start drops asynchronously with reset.
- run at cycle t gives busy=1 at t+1. me_start rises at t+2 when the FIFO is not full.
- me_completed rising at cycle c (sampled) gives CAPTURE at c+1. The entry is visible at out_valid by c+2.
- me_start falls at c+2 and stays low for at least 1 cycle. The next launch is no earlier than c+4.
- Outputs are registered from the FIFO head and stable while out_valid && !out_ready.
- A completion arriving on the same cycle the watchdog hits TIMEOUT is taken as a completion: real data, timeout=0.

## Structure
- Package me_pkg holds:
  - DIST_W and MV_W defaults.
  - typedef me_result_t, a packed struct {distance, mv_x, mv_y, block_idx, timeout}.
  - the seq_state_e enum.
- Sub-module me_result_fifo: synchronous FIFO of me_result_t, DEPTH entries, with push/pop/full/empty/count ports and asynchronous active-high reset.

## Test plan
- Basic frame: NUM_BLOCKS=4, out_ready=1, core model completes 20 cycles after each start with distances 10,20,30,40. Required: 4 entries with block_idx 0..3 in order, frame_sad=100, one frame_done pulse, me_start low ≥1 cycle between launches.
- Backpressure: DEPTH=2, out_ready=0. Required: exactly 2 launches, then me_start held 0. Raising out_ready pops both entries and the remaining 2 blocks complete.
- Timeout: TIMEOUT=50, core never completes block 1. Required: entry idx1 with distance 0xFF, MVs 0, out_timeout=1, and the frame still finishes.
- Signed passthrough: core returns mv_x=−8 (4'b1000), mv_y=+7, distance 0xFF. Required: bit-exact output and frame_sad including 255.
- Run while busy plus mid-frame reset: a second run during block 2 is ignored. A reset at block 2 clears FIFO, busy and me_start. A run after reset restarts at block_idx 0.
